busca_instrucao: RTL
====================

Name: busca_instrucao

Overview:
Instruction-fetch and program-counter unit. It sits on the datapath side of the multicycle processor, at the opposite end of the control interface from the controller. It consumes the controller's PC-write controls (EscCP, EscCondCP, FonteCP) and the ULA zero flag. It fetches instructions from instruction memory over a req/ack handshake, holds them in the IR, and presents opcode and operand fields back to the controller and register bank.

Parameters:
LARGURA_PC, 8, PC and instruction-memory address width
LARGURA_INSTR, 16, instruction word width (fixed format below; must be 16)
PC_RESET, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
EscCP  in  1  unconditional PC write request from controller
EscCondCP  in  1  conditional PC write (branch) request from controller
FonteCP  in  2  PC source select: 00 PC+1, 01 ula_resultado, 10 jump target, 11 hold PC
zero  in  1  ULA zero flag, qualifies EscCondCP
ula_resultado  in  LARGURA_PC  branch target computed by ULA
mem_req  out  1  instruction-memory read request
mem_addr  out  LARGURA_PC  read address (= PC)
mem_ack  in  1  memory read complete; mem_dado valid this cycle
mem_dado  in  LARGURA_INSTR  instruction word from memory
opcode  out  4  IR[15:12]
rd  out  4  IR[11:8]
rs  out  4  IR[7:4]
rt  out  4  IR[3:0]
imediato  out  8  IR[7:0]
pc  out  LARGURA_PC  current PC
instr_valida  out  1  IR holds the instruction fetched from the current PC
ocupado  out  1  fetch in progress (state != DECODIFICADA)

Behaviour:
- Reset (rst_n=0, asynchronous): pc=PC_RESET, IR=0 (so opcode/rd/rs/rt/imediato=0), mem_req=0, instr_valida=0, ocupado=1, state=INICIO. Reset mid-fetch abandons the transaction; a late mem_ack after reset is ignored unless the unit is in BUSCA.
- FSM states: INICIO, BUSCA, DECODIFICADA.
- INICIO: lasts exactly one cycle after reset release, then moves to BUSCA. mem_req=0.
- BUSCA:
  - mem_req=1 and mem_addr=pc, held stable until mem_ack.
  - On the edge where mem_ack=1: IR<=mem_dado, mem_req falls, state goes to DECODIFICADA, and instr_valida=1 from the next cycle.
  - mem_ack in the first BUSCA cycle is legal, giving a minimum fetch latency of 1 cycle.
  - EscCP, EscCondCP and FonteCP are ignored in this state.
- DECODIFICADA: IR and pc hold; instr_valida=1. The unit waits for a PC update:
  - EscCondCP=1 and zero=1: pc<=source(FonteCP) (branch taken).
  - EscCondCP=1 and zero=0: pc<=pc+1 (not taken), regardless of EscCP.
  - EscCondCP=0 and EscCP=1: pc<=source(FonteCP).
  - In all three update cases, state goes to BUSCA on the same edge and instr_valida=0 from the next cycle.
  - Neither control asserted: no change.
- Source mux:
  - 00: pc+1, modulo 2^LARGURA_PC (wraps from all-ones to 0).
  - 01: ula_resultado.
  - 10: IR[LARGURA_PC-1:0] (absolute jump target).
  - 11: pc unchanged, but a refetch is still performed.
- mem_ack outside BUSCA is ignored.
- Outputs opcode/rd/rs/rt/imediato are driven directly from the IR and keep the previous instruction during BUSCA. Consumers qualify them with instr_valida.
- ocupado=1 in INICIO and BUSCA, 0 in DECODIFICADA.
- All outputs are registered or derived from registers only; there is no combinational path from input to output except mem_addr=pc.

Test Plan:
- Reset then memory acks after 3 cycles with 16'h1A23: mem_req high at addr 0 from cycle 2 to the ack. After the ack: opcode=1, rd=A, rs=2, rt=3, imediato=8'h23, instr_valida=1, ocupado=0.
- In DECODIFICADA, pulse EscCP=1, FonteCP=00 with pc=8'hFF: pc becomes 8'h00, instr_valida drops, and a new mem_req goes out at address 0.
- Jump: IR=16'hB042, EscCP=1, FonteCP=10: pc=8'h42 and the refetch is at 8'h42.
- Branch: EscCondCP=1, EscCP=1, FonteCP=01, ula_resultado=8'h30. With zero=1, pc goes to 8'h30. With zero=0 from pc=8'h05, pc goes to 8'h06.
- EscCP pulsed during BUSCA and stray mem_ack in DECODIFICADA: pc and IR are unchanged. Zero-wait ack (mem_ack=1 in the first BUSCA cycle) loads the IR in 1 cycle.
- rst_n asserted while mem_req=1: all outputs immediately take their reset values. A mem_ack arriving during INICIO is ignored, and the next fetch is from PC_RESET.

Source files
------------

// File: rtl/busca_instrucao_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// The request stays high with a stable address until the acknowledge cycle.
interface busca_instrucao_if #(
  parameter int LARGURA_PC    = 8,
  parameter int LARGURA_INSTR = 16
);
  logic                     mem_req;
  logic [LARGURA_PC-1:0]    mem_addr;
  logic                     mem_ack;
  logic [LARGURA_INSTR-1:0] mem_dado;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_dado);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_dado);
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch and PC unit of the multicycle datapath: fetches into the IR over
// a req/ack bus and updates the PC from the controller's EscCP/EscCondCP/FonteCP.
module busca_instrucao #(
  parameter int                    LARGURA_PC    = 8,
  parameter int                    LARGURA_INSTR = 16,
  parameter logic [LARGURA_PC-1:0] PC_RESET      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EscCP,
  input  logic                  EscCondCP,
  input  logic [1:0]            FonteCP,
  input  logic                  zero,
  input  logic [LARGURA_PC-1:0] ula_resultado,
  busca_instrucao_if.master     bus,
  output logic [3:0]            opcode,
  output logic [3:0]            rd,
  output logic [3:0]            rs,
  output logic [3:0]            rt,
  output logic [7:0]            imediato,
  output logic [LARGURA_PC-1:0] pc,
  output logic                  instr_valida,
  output logic                  ocupado
);

  typedef enum logic [1:0] {INICIO, BUSCA, DECODIFICADA} estado_t;

  estado_t                  estado, estado_prox;
  logic [LARGURA_PC-1:0]    pc_prox, pc_inc, pc_fonte;
  logic [LARGURA_INSTR-1:0] ir, ir_prox;

  assign pc_inc = pc + LARGURA_PC'(1);

  // FonteCP 11 keeps the PC but the update still triggers a refetch.
  always_comb begin
    pc_fonte = pc;
    case (FonteCP)
      2'b00:   pc_fonte = pc_inc;
      2'b01:   pc_fonte = ula_resultado;
      2'b10:   pc_fonte = ir[LARGURA_PC-1:0];
      default: pc_fonte = pc;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    estado_prox = estado;
    pc_prox     = pc;
    ir_prox     = ir;
    case (estado)
      INICIO: estado_prox = BUSCA;
      BUSCA: begin
        if (bus.mem_ack) begin
          ir_prox     = bus.mem_dado;
          estado_prox = DECODIFICADA;
        end
      end
      DECODIFICADA: begin
        if (EscCondCP && !zero) begin
          pc_prox     = pc_inc;
          estado_prox = BUSCA;
        end else if (EscCondCP || EscCP) begin
          pc_prox     = pc_fonte;
          estado_prox = BUSCA;
        end
      end
      default: estado_prox = INICIO;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values. The IR is reset too: its fields drive outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= INICIO;
      pc     <= PC_RESET;
      ir     <= '0;
    end else begin
      estado <= estado_prox;
      pc     <= pc_prox;
      ir     <= ir_prox;
    end
  end

  assign bus.mem_req  = (estado == BUSCA);
  assign bus.mem_addr = pc;
  assign instr_valida = (estado == DECODIFICADA);
  assign ocupado      = (estado != DECODIFICADA);

  assign opcode   = ir[15:12];
  assign rd       = ir[11:8];
  assign rs       = ir[7:4];
  assign rt       = ir[3:0];
  assign imediato = ir[7:0];

endmodule
